// File: rtl/instr_fetch_stage.sv
// Fetch stage between the program counter and decode.
// Samples pc, runs one req/ack read to instruction memory, and presents the
// fetched word to decode through a one-entry valid/ready output register.
// Wrong-path data is dropped on redirect.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   pc, redirect        current pc and "pc loads a non-sequential target" flag
//   pc_stall            1 = pc must hold this cycle
//   imem_req/addr       memory read request and address (held until ack)
//   imem_ack/rdata      memory read completion and data
//   instr/instr_pc      fetched word and the address it came from
//   instr_valid/ready   decode handshake
//   fetch_err           sticky: a request waited 2**TMO_W-1 cycles or more
module instr_fetch_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TMO_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              redirect,
  output logic              pc_stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              fetch_err
);

  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] skid_data;
  logic [TMO_W-1:0]  timer;
  logic [TMO_W-1:0]  timer_inc;
  logic              slot_free;

  // Output register can accept a new word this cycle.
  assign slot_free = !instr_valid || instr_ready;

  // Saturating wait-cycle count.
  assign timer_inc = (timer == TMO_MAX) ? timer : timer + TMO_W'(1);

  // pc may only advance on the cycle a new fetch address is sampled.
  assign pc_stall = rst || !((state == IDLE) && slot_free && !redirect);

  // imem_addr doubles as the latched request address for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      skid_data   <= '0;
      timer       <= '0;
      fetch_err   <= 1'b0;
    end else begin
      // Consume or redirect empties the slot unless a capture below refills it.
      if (redirect || (instr_valid && instr_ready)) begin
        instr_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          timer <= '0;
          if (slot_free && !redirect) begin
            imem_addr <= pc;
            imem_req  <= 1'b1;
            state     <= WAIT;
          end
        end

        WAIT: begin
          timer <= timer_inc;
          if (timer_inc == TMO_MAX) begin
            fetch_err <= 1'b1;
          end
          if (imem_ack) begin
            imem_req <= 1'b0;
            timer    <= '0;
            if (redirect) begin
              state <= IDLE;
            end else if (slot_free) begin
              instr       <= imem_rdata;
              instr_pc    <= imem_addr;
              instr_valid <= 1'b1;
              state       <= IDLE;
            end else begin
              skid_data <= imem_rdata;
              state     <= HOLD;
            end
          end else if (redirect) begin
            // Outstanding read must still complete; its data is dropped.
            state <= FLUSH;
          end
        end

        HOLD: begin
          if (redirect) begin
            skid_data <= '0;
            state     <= IDLE;
          end else if (slot_free) begin
            instr       <= skid_data;
            instr_pc    <= imem_addr;
            instr_valid <= 1'b1;
            state       <= IDLE;
          end
        end

        FLUSH: begin
          timer <= timer_inc;
          if (timer_inc == TMO_MAX) begin
            fetch_err <= 1'b1;
          end
          if (imem_ack) begin
            imem_req <= 1'b0;
            timer    <= '0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: pc model, memory model with programmable ack
// delay, and a scoreboard monitor checking every word decode consumes.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_tgt = '0;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        fetch_err;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_consumed = 0;
  logic        saw_dead = 1'b0;
  int          ack_dly = 1;
  int          wait_cnt = 0;
  logic        mem_hold = 1'b0;
  logic [31:0] dead_addr = 32'hFFFF_FFFC;
  logic        early_err;

  instr_fetch_stage #(.ADDR_W(32), .DATA_W(32), .TMO_W(8)) dut (
    .clk(clk), .rst(rst), .pc(pc), .redirect(redirect), .pc_stall(pc_stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_for(input logic [31:0] a);
    return (a * 32'd7) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.pc = a;
    e.data = data_for(a);
    exp_q.push_back(e);
  endtask

  // Program counter as the top level would update it.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else if (redirect) pc <= redirect_tgt;
    else if (!pc_stall) pc <= pc + 32'd4;
  end

  // Instruction memory: ack ack_dly cycles after the request is seen.
  always @(negedge clk) begin
    if (rst || !imem_req || mem_hold) begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= ack_dly) begin
      imem_ack   = 1'b1;
      imem_rdata = (imem_addr == dead_addr) ? 32'hDEAD_BEEF : data_for(imem_addr);
      wait_cnt   = 0;
    end else begin
      imem_ack = 1'b0;
      wait_cnt++;
    end
  end

  // Scoreboard monitor: every handshake pops one expected word.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (instr_valid && instr == 32'hDEAD_BEEF) saw_dead = 1'b1;
      if (instr_valid && instr_ready) begin
        n_consumed++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: got pc %h instr %h expected no word", instr_pc, instr);
        end else begin
          e = exp_q.pop_front();
          check("sb_word", {instr_pc, instr}, {e.pc, e.data});
        end
      end
    end
  end

  task automatic wait_consumed(input int n);
    for (int i = 0; i < 1000 && n_consumed < n; i++) begin
      @(posedge clk); #2;
    end
    check("wait_consumed", 64'(n_consumed), 64'(n));
  endtask

  task automatic wait_req(input logic v);
    for (int i = 0; i < 1000 && imem_req !== v; i++) begin
      @(posedge clk); #2;
    end
    check("wait_req", 64'(imem_req), 64'(v));
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 1000 && instr_valid !== 1'b1; i++) begin
      @(posedge clk); #2;
    end
    check("wait_valid", 64'(instr_valid), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and first sequential fetches.
    push(32'h0); push(32'h4); push(32'h8); push(32'hC); push(32'h10);
    @(posedge clk); #1;
    check("rst_pc_stall", 64'(pc_stall), 64'd1);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_instr_pc", 64'(instr_pc), 64'd0);
    check("rst_err", 64'(fetch_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #2;
    wait_req(1'b1);
    check("first_addr", 64'(imem_addr), 64'h0);
    wait_req(1'b0);
    wait_req(1'b1);
    check("second_addr", 64'(imem_addr), 64'h4);

    // Backpressure: word at 0x10 must sit unchanged while decode stalls.
    wait_consumed(4);
    instr_ready = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("stall_word", {instr_pc, instr}, {32'h10, data_for(32'h10)});
      check("stall_pc", 64'(pc_stall), 64'd1);
    end
    instr_ready = 1'b1;
    wait_consumed(5);

    // Redirect during WAIT without ack: flush, drop 0xDEADBEEF, refetch at 0x100.
    push(32'h100); push(32'h104); push(32'h200); push(32'h204);
    dead_addr = 32'h14;
    ack_dly = 4;
    redirect_tgt = 32'h100;
    redirect = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b0;
    check("flush_req", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h14});
    check("flush_valid", 64'(instr_valid), 64'd0);
    wait_req(1'b0);
    ack_dly = 1;
    wait_req(1'b1);
    check("redir_addr", 64'(imem_addr), 64'h100);

    // Redirect on the ack edge: data dropped, back to IDLE.
    wait_consumed(7);
    dead_addr = 32'h108;
    redirect_tgt = 32'h200;
    @(posedge clk); #1;
    redirect = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b0;
    check("ackredir_valid", 64'(instr_valid), 64'd0);
    check("ackredir_req", 64'(imem_req), 64'd0);

    // Timeout: ack withheld, fetch_err rises after 255 waiting cycles.
    wait_consumed(8);
    mem_hold = 1'b1;
    early_err = 1'b0;
    for (int k = 1; k <= 255; k++) begin
      @(posedge clk); #2;
      if (k < 255 && fetch_err) early_err = 1'b1;
      if (k == 254) check("err_before_255", 64'(fetch_err), 64'd0);
      if (k == 255) check("err_at_255", 64'(fetch_err), 64'd1);
    end
    check("no_early_err", 64'(early_err), 64'd0);
    repeat (5) begin @(posedge clk); #2; end
    check("tmo_req_held", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h204});
    check("err_sticky", 64'(fetch_err), 64'd1);
    mem_hold = 1'b0;
    wait_consumed(9);
    check("err_after_ack", 64'(fetch_err), 64'd1);

    // Asynchronous reset in WAIT.
    rst = 1'b1;
    #1;
    check("rstw_req", 64'(imem_req), 64'd0);
    check("rstw_addr", 64'(imem_addr), 64'd0);
    check("rstw_err", 64'(fetch_err), 64'd0);
    check("rstw_stall", 64'(pc_stall), 64'd1);
    check("rstw_valid", 64'(instr_valid), 64'd0);
    @(posedge clk); #1;
    instr_ready = 1'b0;
    rst = 1'b0;

    // Asynchronous reset with a word held in the output register.
    wait_valid();
    #1;
    rst = 1'b1;
    #1;
    check("rsth_valid", 64'(instr_valid), 64'd0);
    check("rsth_word", {instr_pc, instr}, 64'd0);
    check("rsth_stall", 64'(pc_stall), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    check("no_deadbeef", 64'(saw_dead), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
